// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined add/subtract unit: chunk geometry and its
// elaboration-time sanity check.
package adder_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational ripple-carry slice; c_msb_in is the carry entering the top bit
// so the last stage can derive signed overflow.
module rca_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  always_comb begin
    logic c;
    c        = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_pipe_param.sv
// Pipelined add/subtract: one carry chunk resolved per stage, operands shifted
// down so every stage works on its low chunk; one global stall from the output.
module adder_pipe_param
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("adder_pipe_param: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             cy_q    [STAGES];
  logic             ovf_q;

  logic             stall;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign stall    = valid_q[STAGES-1] & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Subtraction as a + ~b + ~cin so the same carry chain serves both modes.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic             cy_in;
    logic [CHUNK-1:0] cs;
    logic             cc;
    logic             cm;

    if (k == 0) begin : g_head
      assign v_in   = in_valid;
      assign a_in   = a;
      assign b_in   = b_eff;
      assign sum_in = '0;
      assign cy_in  = c0;
    end else begin : g_body
      assign v_in   = valid_q[k-1];
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign sum_in = sum_q[k-1];
      assign cy_in  = cy_q[k-1];
    end

    rca_chunk #(.N(CHUNK)) u_rca (
      .a        (a_in[CHUNK-1:0]),
      .b        (b_in[CHUNK-1:0]),
      .cin      (cy_in),
      .s        (cs),
      .cout     (cc),
      .c_msb_in (cm)
    );

    // Data only moves with a valid beat so outputs hold their last result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        cy_q[k]    <= 1'b0;
      end else if (adv) begin
        valid_q[k] <= v_in;
        if (v_in) begin
          a_q[k]   <= a_in >> CHUNK;
          b_q[k]   <= b_in >> CHUNK;
          sum_q[k] <= sum_in | (WIDTH'(cs) << (k * CHUNK));
          cy_q[k]  <= cc;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && v_in) begin
          ovf_q <= cm ^ cc;
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe_param.sv
// Bench for adder_pipe_param: directed cases on a 4-stage unit, then a random
// handshake sweep over 1/2/4/16-stage units against an arithmetic model.
module tb_adder_pipe_param;

  localparam int W      = 16;
  localparam int N_INST = 4;
  localparam int D      = 2;
  localparam int QDEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [N_INST];
  logic         in_ready  [N_INST];
  logic [W-1:0] a         [N_INST];
  logic [W-1:0] b         [N_INST];
  logic         cin       [N_INST];
  logic         sub       [N_INST];
  logic         out_valid [N_INST];
  logic         out_ready [N_INST];
  logic [W-1:0] s         [N_INST];
  logic         cout      [N_INST];
  logic         ovf       [N_INST];

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] exp_mem [N_INST][QDEPTH];
  int          wr_ptr  [N_INST];
  int          rd_ptr  [N_INST];

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    adder_pipe_param #(.WIDTH(W), .STAGES(ST)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .cin       (cin[g]),
      .sub       (sub[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .s         (s[g]),
      .cout      (cout[g]),
      .ovf       (ovf[g])
    );
  end

  // {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic sb);
    int   ux, uy, sx, sy, ru, rs;
    logic co;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      ru = ux + uy + int'(ci);
      rs = sx + sy + int'(ci);
      co = (ru > 65535);
    end else begin
      ru = ux - uy - int'(ci);
      rs = sx - sy - int'(ci);
      co = (ux >= uy + int'(ci));
    end
    return {(rs > 32767) || (rs < -32768), co, ru[15:0]};
  endfunction

  task automatic idle_all();
    for (int i = 0; i < N_INST; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      a[i]         = '0;
      b[i]         = '0;
      cin[i]       = 1'b0;
      sub[i]       = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic sb, output int lat, output logic [17:0] got);
    @(negedge clk);
    in_valid[D]  = 1'b1;
    out_ready[D] = 1'b1;
    a[D]   = x;
    b[D]   = y;
    cin[D] = ci;
    sub[D] = sb;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid[D] = 1'b0;
    while (!out_valid[D] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = {ovf[D], cout[D], s[D]};
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    for (int i = 0; i < N_INST; i++) begin
      n_cmp++;
      if ({out_valid[i], cout[i], ovf[i], s[i]} !== 19'd0) begin
        n_err++;
        $display("FAIL reset_state inst%0d: got valid=%b cout=%b ovf=%b s=%h, want all 0",
                 i, out_valid[i], cout[i], ovf[i], s[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N_INST; i++) begin
      n_cmp++;
      if (in_ready[i] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_in_ready inst%0d: got %b, want 1", i, in_ready[i]);
      end
    end
  endtask

  task automatic check_directed(input string name, input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb, input logic [17:0] want);
    int          lat;
    logic [17:0] got;
    send_one(x, y, ci, sb, lat, got);
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles, want 4", name, lat);
    end
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s_result: got ovf=%b cout=%b s=%h, want ovf=%b cout=%b s=%h",
               name, got[17], got[16], got[15:0], want[17], want[16], want[15:0]);
    end
  endtask

  task automatic test_add();
    check_directed("add", 16'h1234, 16'h0FF0, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2224});
    check_directed("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100});
  endtask

  task automatic test_wrap();
    check_directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    check_directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
  endtask

  task automatic test_sub();
    check_directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    check_directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    check_directed("sub_bin", 16'h0010, 16'h0010, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFF});
  endtask

  task automatic test_back_to_back();
    logic [15:0] xa [8];
    logic [15:0] xb [8];
    logic        xc [8];
    logic        xs [8];
    int          sent, recv;
    logic [17:0] want;
    for (int i = 0; i < 8; i++) begin
      xa[i] = 16'($urandom);
      xb[i] = 16'($urandom);
      xc[i] = 1'($urandom);
      xs[i] = 1'($urandom);
    end
    do_reset();
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      @(negedge clk);
      out_ready[D] = !(c >= 5 && c <= 9);
      in_valid[D]  = (sent < 8);
      if (sent < 8) begin
        a[D]   = xa[sent];
        b[D]   = xb[sent];
        cin[D] = xc[sent];
        sub[D] = xs[sent];
      end
      #1;
      n_cmp++;
      if (in_ready[D] !== !(out_valid[D] && !out_ready[D])) begin
        n_err++;
        $display("FAIL bp_in_ready cycle %0d: got %b with out_valid=%b out_ready=%b",
                 c, in_ready[D], out_valid[D], out_ready[D]);
      end
      if (out_valid[D] && out_ready[D]) begin
        want = ref_model(xa[recv], xb[recv], xc[recv], xs[recv]);
        n_cmp++;
        if ({ovf[D], cout[D], s[D]} !== want) begin
          n_err++;
          $display("FAIL bp_result beat %0d: got ovf=%b cout=%b s=%h, want ovf=%b cout=%b s=%h",
                   recv, ovf[D], cout[D], s[D], want[17], want[16], want[15:0]);
        end
        recv++;
      end
      if (in_valid[D] && in_ready[D]) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid[D] = 1'b0;
    n_cmp++;
    if (recv !== 8) begin
      n_err++;
      $display("FAIL bp_count: got %0d results, want 8", recv);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (out_valid[D] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_duplicate: got out_valid=%b after all beats, want 0", out_valid[D]);
    end
  endtask

  task automatic test_reset_midstream();
    int          lat;
    logic [17:0] got;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready[D] = 1'b0;
      in_valid[D]  = (c < 3);
      a[D]   = 16'(16'h1111 * (c + 1));
      b[D]   = 16'h0101;
      cin[D] = 1'b0;
      sub[D] = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid[D] = 1'b0;
    #1;
    n_cmp++;
    if (out_valid[D] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: got out_valid=%b, want 1", out_valid[D]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid[D], in_ready[D]} !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_async: got out_valid=%b in_ready=%b, want 0 1",
               out_valid[D], in_ready[D]);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready[D] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[D] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_stale cycle %0d: got out_valid=%b, want 0", c, out_valid[D]);
      end
    end
    send_one(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, lat, got);
    n_cmp++;
    if (lat !== 4 || got !== {1'b0, 1'b0, 16'hB4B5}) begin
      n_err++;
      $display("FAIL midrst_new: got lat=%0d ovf=%b cout=%b s=%h, want lat=4 ovf=0 cout=0 s=b4b5",
               lat, got[17], got[16], got[15:0]);
    end
  endtask

  task automatic test_random_sweep();
    logic [17:0] want;
    do_reset();
    for (int i = 0; i < N_INST; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N_INST; i++) begin
        in_valid[i]  = (cyc < 1200) && ($urandom_range(0, 99) < 70);
        out_ready[i] = (cyc >= 1200) || ($urandom_range(0, 99) < 65);
        a[i]   = 16'($urandom);
        b[i]   = 16'($urandom);
        cin[i] = 1'($urandom);
        sub[i] = 1'($urandom);
      end
      #1;
      for (int i = 0; i < N_INST; i++) begin
        n_cmp++;
        if (in_ready[i] !== !(out_valid[i] && !out_ready[i])) begin
          n_err++;
          $display("FAIL sweep_in_ready inst%0d cycle %0d: got %b with out_valid=%b out_ready=%b",
                   i, cyc, in_ready[i], out_valid[i], out_ready[i]);
        end
        if (out_valid[i] && out_ready[i]) begin
          n_cmp++;
          if (rd_ptr[i] >= wr_ptr[i]) begin
            n_err++;
            $display("FAIL sweep_extra inst%0d cycle %0d: got unexpected s=%h, want no result",
                     i, cyc, s[i]);
          end else begin
            want = exp_mem[i][rd_ptr[i] % QDEPTH];
            if ({ovf[i], cout[i], s[i]} !== want) begin
              n_err++;
              $display("FAIL sweep_result inst%0d beat %0d: got ovf=%b cout=%b s=%h, want ovf=%b cout=%b s=%h",
                       i, rd_ptr[i], ovf[i], cout[i], s[i], want[17], want[16], want[15:0]);
            end
            rd_ptr[i]++;
          end
        end
        if (in_valid[i] && in_ready[i]) begin
          exp_mem[i][wr_ptr[i] % QDEPTH] = ref_model(a[i], b[i], cin[i], sub[i]);
          wr_ptr[i]++;
        end
      end
      @(posedge clk);
    end
    for (int i = 0; i < N_INST; i++) begin
      n_cmp++;
      if (rd_ptr[i] !== wr_ptr[i] || wr_ptr[i] < 100) begin
        n_err++;
        $display("FAIL sweep_drain inst%0d: got %0d results, want %0d (accepted)",
                 i, rd_ptr[i], wr_ptr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_back_to_back();
    test_reset_midstream();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
